// File: rtl/accelerator_matrix_row_max_subtractor_if.sv
// Handshake and data bus for the row-max subtractor stage.
// The master drives sizes and input elements, and the slave returns the row-normalised elements.
interface accelerator_matrix_row_max_subtractor_if #(
    parameter int DATA_SIZE = 64
);
    logic                 START;
    logic                 READY;
    logic                 DATA_IN_MATRIX_ENABLE;
    logic                 DATA_IN_READY;
    logic                 DATA_OUT_MATRIX_ENABLE;
    logic                 DATA_OUT_VECTOR_ENABLE;
    logic [DATA_SIZE-1:0] SIZE_I_IN;
    logic [DATA_SIZE-1:0] SIZE_J_IN;
    logic [DATA_SIZE-1:0] DATA_IN;
    logic [DATA_SIZE-1:0] DATA_OUT;

    modport master (
        output START, DATA_IN_MATRIX_ENABLE, SIZE_I_IN, SIZE_J_IN, DATA_IN,
        input  READY, DATA_IN_READY, DATA_OUT_MATRIX_ENABLE,
        input  DATA_OUT_VECTOR_ENABLE, DATA_OUT
    );

    modport slave (
        input  START, DATA_IN_MATRIX_ENABLE, SIZE_I_IN, SIZE_J_IN, DATA_IN,
        output READY, DATA_IN_READY, DATA_OUT_MATRIX_ENABLE,
        output DATA_OUT_VECTOR_ENABLE, DATA_OUT
    );
endinterface

// File: rtl/accelerator_matrix_row_max_subtractor.sv
// Buffers one matrix row, tracks its signed maximum, then streams x - max per element.
// The result feeds the softmax stage.
module accelerator_matrix_row_max_subtractor #(
    parameter int DATA_SIZE    = 64,
    parameter int CONTROL_SIZE = 4
) (
    input logic CLK,
    input logic RST,
    accelerator_matrix_row_max_subtractor_if.slave bus
);
    localparam int DEPTH = 2 ** CONTROL_SIZE;
    localparam logic [DATA_SIZE-1:0] DEPTH_W = DATA_SIZE'(DEPTH);
    localparam logic [DATA_SIZE-1:0] ONE = DATA_SIZE'(1);

    typedef enum logic [1:0] {
        IDLE,
        INPUT_ROW,
        OUTPUT_ROW,
        ENDER
    } state_t;

    state_t state;

    logic [DATA_SIZE-1:0] size_i;
    logic [DATA_SIZE-1:0] size_j;
    logic [DATA_SIZE-1:0] row;
    logic [DATA_SIZE-1:0] col;
    logic signed [DATA_SIZE-1:0] max_val;
    logic [DATA_SIZE-1:0] buffer [DEPTH];

    logic [DATA_SIZE-1:0] data_out;
    logic                 ready;
    logic                 out_en;
    logic                 vec_en;

    logic [DATA_SIZE-1:0]    size_j_clamp;
    logic [CONTROL_SIZE-1:0] idx;
    logic                    accept;
    logic                    last_col;
    logic                    last_row;

    assign size_j_clamp = (bus.SIZE_J_IN > DEPTH_W) ? DEPTH_W : bus.SIZE_J_IN;
    assign idx      = col[CONTROL_SIZE-1:0];
    assign accept   = (state == INPUT_ROW) && bus.DATA_IN_MATRIX_ENABLE;
    assign last_col = (col == size_j - ONE);
    assign last_row = (row == size_i - ONE);

    // Row storage carries no reset; every slot is written before it is read.
    always_ff @(posedge CLK) begin
        if (accept) begin
            buffer[idx] <= bus.DATA_IN;
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state    <= IDLE;
            size_i   <= '0;
            size_j   <= '0;
            row      <= '0;
            col      <= '0;
            max_val  <= '0;
            data_out <= '0;
            ready    <= 1'b0;
            out_en   <= 1'b0;
            vec_en   <= 1'b0;
        end else begin
            ready  <= 1'b0;
            out_en <= 1'b0;
            vec_en <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.START) begin
                        size_i <= bus.SIZE_I_IN;
                        size_j <= size_j_clamp;
                        row    <= '0;
                        col    <= '0;
                        if (bus.SIZE_I_IN == '0 || size_j_clamp == '0) begin
                            state <= ENDER;
                        end else begin
                            state <= INPUT_ROW;
                        end
                    end
                end
                INPUT_ROW: begin
                    if (bus.DATA_IN_MATRIX_ENABLE) begin
                        // First column seeds the max so nothing leaks from the previous row.
                        if (col == '0 || $signed(bus.DATA_IN) > max_val) begin
                            max_val <= bus.DATA_IN;
                        end
                        if (last_col) begin
                            col   <= '0;
                            state <= OUTPUT_ROW;
                        end else begin
                            col <= col + ONE;
                        end
                    end
                end
                OUTPUT_ROW: begin
                    data_out <= buffer[idx] - max_val;
                    out_en   <= 1'b1;
                    if (last_col) begin
                        vec_en <= 1'b1;
                        col    <= '0;
                        if (last_row) begin
                            state <= ENDER;
                        end else begin
                            row   <= row + ONE;
                            state <= INPUT_ROW;
                        end
                    end else begin
                        col <= col + ONE;
                    end
                end
                ENDER: begin
                    ready <= 1'b1;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.DATA_IN_READY          = (state == INPUT_ROW);
    assign bus.READY                  = ready;
    assign bus.DATA_OUT               = data_out;
    assign bus.DATA_OUT_MATRIX_ENABLE = out_en;
    assign bus.DATA_OUT_VECTOR_ENABLE = vec_en;
endmodule

// File: doc/accelerator_matrix_row_max_subtractor.md
ACCELERATOR_MATRIX_ROW_MAX_SUBTRACTOR -- requirements
Module: accelerator_matrix_row_max_subtractor

Interface
REQ-001 SHALL have parameter DATA_SIZE, default 64, element/size width in bits.
REQ-002 SHALL have parameter CONTROL_SIZE, default 4; row buffer depth is 2^CONTROL_SIZE elements.
REQ-003 CLK  input  1  clock; all state changes on rising edge.
REQ-004 RST  input  1  reset, asynchronous, active-high.
REQ-005 START  input  1  begins a matrix operation when sampled high in IDLE.
REQ-006 READY  output  1  one-cycle pulse when the whole matrix has been output.
REQ-007 DATA_IN_MATRIX_ENABLE  input  1  input element strobe.
REQ-008 DATA_IN_READY  output  1  high while the block accepts input elements.
REQ-009 DATA_OUT_MATRIX_ENABLE  output  1  one-cycle pulse marking a valid DATA_OUT element.
REQ-010 DATA_OUT_VECTOR_ENABLE  output  1  pulse coincident with the last element of each output row.
REQ-011 SIZE_I_IN  input  DATA_SIZE  number of rows.
REQ-012 SIZE_J_IN  input  DATA_SIZE  number of columns.
REQ-013 DATA_IN  input  DATA_SIZE  signed two's-complement input element, row-major.
REQ-014 DATA_OUT  output  DATA_SIZE  signed element x[i][j] - max_j(x[i][j]), fed to the softmax stage.

Function
REQ-015 SHALL implement states IDLE, INPUT_ROW, OUTPUT_ROW, ENDER; no other state reachable; an illegal encoding SHALL return to IDLE next cycle.
REQ-016 IDLE: START=1 latches SIZE_I_IN and SIZE_J_IN, clears row/column counters, enters INPUT_ROW; START outside IDLE SHALL be ignored.
REQ-017 Latched SIZE_J values above 2^CONTROL_SIZE SHALL be clamped to 2^CONTROL_SIZE.
REQ-018 If latched SIZE_I or SIZE_J is 0, SHALL go IDLE -> ENDER with no DATA_OUT_MATRIX_ENABLE pulses.
REQ-019 DATA_IN_READY SHALL be 1 exactly while in INPUT_ROW.
REQ-020 INPUT_ROW: each cycle with DATA_IN_MATRIX_ENABLE=1 writes DATA_IN to buffer[j], increments j; j=0 loads running max directly, j>0 updates max with signed compare.
REQ-021 DATA_IN_MATRIX_ENABLE=0 SHALL stall without changing counters, buffer or max; strobes outside INPUT_ROW SHALL be ignored.
REQ-022 On acceptance of column SIZE_J-1, SHALL enter OUTPUT_ROW next cycle with j reset to 0; max includes that last element.
REQ-023 OUTPUT_ROW: one element per cycle, no stalls; DATA_OUT registered = buffer[j] - max, DATA_OUT_MATRIX_ENABLE=1 same cycle.
REQ-024 First output of a row SHALL appear in the first OUTPUT_ROW cycle (1 cycle after last input accepted); a row takes exactly SIZE_J cycles.
REQ-025 Subtraction SHALL be DATA_SIZE-bit modulo 2^DATA_SIZE, no saturation.
REQ-026 On the row's last element DATA_OUT_VECTOR_ENABLE=1; next cycle SHALL enter INPUT_ROW (i+1) if i < SIZE_I-1, else ENDER.
REQ-027 ENDER: READY=1 for exactly one cycle, then IDLE; READY=0 in all other cycles.
REQ-028 DATA_OUT SHALL hold its last value when DATA_OUT_MATRIX_ENABLE=0; both enable outputs 0 outside OUTPUT_ROW.
REQ-029 Max SHALL be recomputed per row; no value carries between rows.

Reset
REQ-030 RST=1 SHALL immediately force state IDLE, counters 0, max 0, READY=0, DATA_IN_READY=0, DATA_OUT_MATRIX_ENABLE=0, DATA_OUT_VECTOR_ENABLE=0, DATA_OUT=0.
REQ-031 Reset mid-operation SHALL abandon the matrix; after release no output pulse occurs until a new START.
REQ-032 Buffer contents need not be reset.

Verification
REQ-033 2x3, rows {1,5,3},{-2,-7,-4}, continuous strobes -> outputs {-4,0,-2},{0,-5,-2}; VECTOR_ENABLE on 3rd and 6th; single READY one cycle after 6th.
REQ-034 1x4 with strobe gaps (DATA_IN_MATRIX_ENABLE toggled 1,0,1,0,...) {7,7,7,7} -> outputs {0,0,0,0} in 4 consecutive cycles after last accept.
REQ-035 SIZE_I=3, SIZE_J=0 -> no DATA_OUT_MATRIX_ENABLE, READY pulse 2 cycles after START.
REQ-036 1x2 {-2^63, 2^63-1} (DATA_SIZE=64) -> outputs {1, 0} (wrap), confirming modulo arithmetic.
REQ-037 RST asserted during OUTPUT_ROW of 2x2 -> all outputs 0 same cycle; new START with 1x1 {9} -> output {0}, READY.
REQ-038 START pulsed during INPUT_ROW -> ignored; sizes and counters unchanged, results identical to REQ-033.
